// File: rtl/mips_periph_pkg.sv
// Shared register-map constants and bus types for the MIPS MEM-stage peripherals.
package mips_periph_pkg;

    localparam logic [3:0] TH_OFS   = 4'h0;
    localparam logic [3:0] TL_OFS   = 4'h4;
    localparam logic [3:0] TCON_OFS = 4'h8;

    localparam int EN_B  = 0;
    localparam int IEN_B = 1;
    localparam int ST_B  = 2;

    localparam int CH_STRIDE = 16;
    localparam int PRESC_W   = 16;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/count registers, control bits and sticky overflow status.
module timer_channel
    import mips_periph_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          cnt_en,
    input  logic          wr_th,
    input  logic          wr_tl,
    input  logic          wr_tcon,
    input  logic [31:0]   wdata,
    output logic [CW-1:0] th,
    output logic [CW-1:0] tl,
    output logic [2:0]    tcon,
    output logic          tick
);

    logic en, ien, status;
    logic step, ovf;

    assign step = en & cnt_en;
    assign ovf  = step & (tl == {CW{1'b1}});

    assign tcon[EN_B]  = en;
    assign tcon[IEN_B] = ien;
    assign tcon[ST_B]  = status;

    // Reload reads the current TH, so a TH write in the reload cycle only affects the next wrap.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            th     <= '0;
            tl     <= '0;
            en     <= 1'b0;
            ien    <= 1'b0;
            status <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= ovf;
            if (wr_th)
                th <= wdata[CW-1:0];
            if (wr_tl)
                tl <= wdata[CW-1:0];
            else if (ovf)
                tl <= th;
            else if (step)
                tl <= tl + CW'(1);
            if (wr_tcon) begin
                en  <= wdata[EN_B];
                ien <= wdata[IEN_B];
            end
            // Overflow beats a simultaneous clear so the interrupt is never lost.
            if (ovf)
                status <= 1'b1;
            else if (wr_tcon && !wdata[ST_B])
                status <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_timer_bank.sv
// NCH-channel memory-mapped timer bank with OR-combined interrupt.
// Optional shared prescaler enabled by defining TIMER_PRESCALE_EN.
module mmio_timer_bank
    import mips_periph_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          CW        = 32,
    parameter logic [31:0] ADDR_BASE = 32'h4000_0100
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           rd,
    input  logic           wr,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic           irq,
    output logic [NCH-1:0] tick
);

    localparam logic [31:0] PEND_OFS  = 32'(CH_STRIDE * NCH);
    localparam logic [31:0] PRESC_OFS = PEND_OFS + 32'd4;

    bus_req_t req;
    assign req = '{rd: rd, wr: wr, addr: addr, wdata: wdata};

    logic [31:0] off;
    logic        aligned, ch_hit;
    int          ch_idx;
    logic        cnt_en;

    // Addresses below the base wrap to large offsets and fall outside every range.
    assign off     = req.addr - ADDR_BASE;
    assign aligned = (off[1:0] == 2'b00);
    assign ch_hit  = aligned && (off < PEND_OFS);
    assign ch_idx  = int'(off[6:4]);

    logic [NCH-1:0][CW-1:0] th_all, tl_all;
    logic [NCH-1:0][2:0]    tcon_all;
    logic [NCH-1:0]         pend, ien_v;
    logic [NCH-1:0]         wr_th, wr_tl, wr_tcon;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic sel;
        assign sel        = ch_hit && (off[6:4] == 3'(c));
        assign wr_th[c]   = req.wr && sel && (off[3:0] == TH_OFS);
        assign wr_tl[c]   = req.wr && sel && (off[3:0] == TL_OFS);
        assign wr_tcon[c] = req.wr && sel && (off[3:0] == TCON_OFS);
        assign pend[c]    = tcon_all[c][ST_B];
        assign ien_v[c]   = tcon_all[c][IEN_B];

        timer_channel #(.CW(CW)) u_ch (
            .sysclk  (sysclk),
            .reset   (reset),
            .cnt_en  (cnt_en),
            .wr_th   (wr_th[c]),
            .wr_tl   (wr_tl[c]),
            .wr_tcon (wr_tcon[c]),
            .wdata   (req.wdata),
            .th      (th_all[c]),
            .tl      (tl_all[c]),
            .tcon    (tcon_all[c]),
            .tick    (tick[c])
        );
    end

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc, pc;
    logic               wr_presc;

    assign wr_presc = req.wr && aligned && (off == PRESC_OFS);
    assign cnt_en   = (pc == presc);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            pc    <= '0;
        end else if (wr_presc) begin
            presc <= req.wdata[PRESC_W-1:0];
            pc    <= '0;
        end else if (cnt_en) begin
            pc <= '0;
        end else begin
            pc <= pc + PRESC_W'(1);
        end
    end
`else
    assign cnt_en = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        if (req.rd && aligned) begin
            if (ch_hit) begin
                case (off[3:0])
                    TH_OFS:   rdata = 32'(th_all[ch_idx]);
                    TL_OFS:   rdata = 32'(tl_all[ch_idx]);
                    TCON_OFS: rdata = 32'(tcon_all[ch_idx]);
                    default:  rdata = '0;
                endcase
            end else if (off == PEND_OFS) begin
                rdata = 32'(pend);
            end
`ifdef TIMER_PRESCALE_EN
            else if (off == PRESC_OFS) begin
                rdata = 32'(presc);
            end
`endif
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= |(pend & ien_v);
    end

endmodule
